exe_stage_unit: RTL and testbench

//  Consumer side of the ID/EX pipeline register. Takes decoded ID/EX fields and generates Val2
//  (immediate rotate, register shift, or memory offset). Runs the ALU and owns the NZCV status

---
 rtl/exe_stage_unit.sv | 156 +++++++++++++++
 tb/tb_exe_stage_unit.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_stage_unit.sv
// Execute stage: Val2 generation, ALU, NZCV status register, branch target
// resolution and the EX/MEM pipeline register.
module exe_stage_unit #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         freeze,
    input  logic         valid_in,
    input  logic [W-1:0] pc_in,
    input  logic         wb_en,
    input  logic         mem_r_en,
    input  logic         mem_w_en,
    input  logic         b,
    input  logic         s,
    input  logic [3:0]   exe_cmd,
    input  logic [W-1:0] val_rn,
    input  logic [W-1:0] val_rm,
    input  logic         imm,
    input  logic [11:0]  shift_operand,
    input  logic [23:0]  signed_imm_24,
    input  logic [3:0]   dest,
    output logic         wb_en_out,
    output logic         mem_r_en_out,
    output logic         mem_w_en_out,
    output logic [W-1:0] alu_res,
    output logic [W-1:0] st_data,
    output logic [3:0]   dest_out,
    output logic [3:0]   status,
    output logic         branch_taken,
    output logic [W-1:0] branch_addr
);

    logic [31:0] val2;
    logic [63:0] dbl;
    logic [31:0] imm_ext;
    logic [4:0]  imm_rot;
    logic [4:0]  sh_amt;

    logic [32:0] sum;
    logic [31:0] res;
    logic        op_valid;
    logic        is_add;
    logic        is_sub;
    logic        c_new;
    logic        v_new;
    logic [3:0]  status_d;

    assign imm_ext = {24'b0, shift_operand[7:0]};
    assign imm_rot = {shift_operand[11:8], 1'b0};
    assign sh_amt  = shift_operand[11:7];

    // Operand-2 selection: rotated immediate, memory offset or shifted register.
    always_comb begin
        val2 = val_rm;
        dbl  = '0;
        if (imm) begin
            dbl  = {imm_ext, imm_ext} >> imm_rot;
            val2 = dbl[31:0];
        end else if (mem_r_en || mem_w_en) begin
            val2 = {20'b0, shift_operand};
        end else begin
            unique case (shift_operand[6:5])
                2'b00: val2 = val_rm << sh_amt;
                2'b01: val2 = val_rm >> sh_amt;
                2'b10: val2 = $signed(val_rm) >>> sh_amt;
                2'b11: begin
                    dbl  = {val_rm, val_rm} >> sh_amt;
                    val2 = dbl[31:0];
                end
                default: val2 = val_rm;
            endcase
        end
    end

    // ALU and next-state flags; subtraction is A + ~B + 1 so carry-out is NOT borrow.
    always_comb begin
        sum      = '0;
        res      = '0;
        op_valid = 1'b1;
        is_add   = 1'b0;
        is_sub   = 1'b0;
        unique case (exe_cmd)
            4'b0001: res = val2;
            4'b1001: res = ~val2;
            4'b0010: begin
                sum    = {1'b0, val_rn} + {1'b0, val2};
                is_add = 1'b1;
            end
            4'b0011: begin
                sum    = {1'b0, val_rn} + {1'b0, val2} + {32'b0, status[1]};
                is_add = 1'b1;
            end
            4'b0100: begin
                sum    = {1'b0, val_rn} + {1'b0, ~val2} + 33'd1;
                is_sub = 1'b1;
            end
            4'b0101: begin
                sum    = {1'b0, val_rn} + {1'b0, ~val2} + {32'b0, status[1]};
                is_sub = 1'b1;
            end
            4'b0110: res = val_rn & val2;
            4'b0111: res = val_rn | val2;
            4'b1000: res = val_rn ^ val2;
            default: op_valid = 1'b0;
        endcase
        if (is_add || is_sub) begin
            res = sum[31:0];
        end
        c_new = status[1];
        v_new = status[0];
        if (is_add) begin
            c_new = sum[32];
            v_new = (val_rn[31] == val2[31]) && (res[31] != val_rn[31]);
        end else if (is_sub) begin
            c_new = sum[32];
            v_new = (val_rn[31] != val2[31]) && (res[31] != val_rn[31]);
        end
        status_d = {res[31], (res == 32'b0), c_new, v_new};
    end

    // Branch resolution is combinational so the fetch stage can redirect this cycle.
    always_comb begin
        branch_taken = valid_in & b;
        branch_addr  = pc_in + {{6{signed_imm_24[23]}}, signed_imm_24, 2'b00};
    end

    // NZCV register; only flag-setting, valid, unfrozen instructions update it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status <= 4'b0;
        end else if (valid_in && s && !freeze && op_valid) begin
            status <= status_d;
        end
    end

    // EX/MEM register; bubbles clear the control bits so nothing downstream commits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_en_out    <= 1'b0;
            mem_r_en_out <= 1'b0;
            mem_w_en_out <= 1'b0;
            alu_res      <= '0;
            st_data      <= '0;
            dest_out     <= 4'b0;
        end else if (!freeze) begin
            wb_en_out    <= valid_in & wb_en;
            mem_r_en_out <= valid_in & mem_r_en;
            mem_w_en_out <= valid_in & mem_w_en;
            alu_res      <= res;
            st_data      <= val_rm;
            dest_out     <= dest;
        end
    end

endmodule

// File: tb/tb_exe_stage_unit.sv
// Self-checking bench for exe_stage_unit using an expected-result queue.
module tb_exe_stage_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        valid_in;
    logic [31:0] pc_in;
    logic        wb_en, mem_r_en, mem_w_en, b, s;
    logic [3:0]  exe_cmd;
    logic [31:0] val_rn, val_rm;
    logic        imm;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;
    logic [3:0]  dest;
    logic        wb_en_out, mem_r_en_out, mem_w_en_out;
    logic [31:0] alu_res, st_data;
    logic [3:0]  dest_out, status;
    logic        branch_taken;
    logic [31:0] branch_addr;

    typedef struct packed {
        logic        wb;
        logic        mr;
        logic        mw;
        logic [3:0]  dst;
        logic [31:0] res;
        logic [31:0] st;
    } exp_t;

    exp_t sb[$];
    exp_t got;
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    exe_stage_unit #(.W(32)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .valid_in(valid_in), .pc_in(pc_in),
        .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .b(b), .s(s),
        .exe_cmd(exe_cmd), .val_rn(val_rn), .val_rm(val_rm), .imm(imm),
        .shift_operand(shift_operand), .signed_imm_24(signed_imm_24), .dest(dest),
        .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
        .alu_res(alu_res), .st_data(st_data), .dest_out(dest_out), .status(status),
        .branch_taken(branch_taken), .branch_addr(branch_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic exp_t out_now();
        return {wb_en_out, mem_r_en_out, mem_w_en_out, dest_out, alu_res, st_data};
    endfunction

    task automatic op(input logic v, input logic [3:0] cmd, input logic sf, input logic im,
                      input logic [11:0] so, input logic [31:0] rn, input logic [31:0] rm,
                      input logic w, input logic mr, input logic mw, input logic [3:0] d);
        valid_in = v; exe_cmd = cmd; s = sf; imm = im; shift_operand = so;
        val_rn = rn; val_rm = rm; wb_en = w; mem_r_en = mr; mem_w_en = mw; dest = d;
    endtask

    task automatic test_reset();
        rst = 1'b1; freeze = 1'b0; b = 1'b0; pc_in = '0; signed_imm_24 = '0;
        op(1'b0, 4'd0, 1'b0, 1'b0, 12'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_now() !== 71'b0) begin
            errors++; $display("FAIL reset_outputs got %h exp 0", out_now());
        end
        checks++;
        if (status !== 4'b0) begin
            errors++; $display("FAIL reset_status got %b exp 0000", status);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add_flags();
        @(negedge clk);
        op(1'b1, 4'b0010, 1'b1, 1'b1, 12'h001, 32'h7FFFFFFF, 32'h1234, 1'b1, 1'b0, 1'b0, 4'd3);
        sb.push_back({1'b1, 1'b0, 1'b0, 4'd3, 32'h80000000, 32'h1234});
        @(posedge clk); #1;
        got = out_now(); e = sb.pop_front();
        checks++;
        if (got !== e) begin errors++; $display("FAIL add_out got %h exp %h", got, e); end
        checks++;
        if (status !== 4'b1001) begin
            errors++; $display("FAIL add_status got %b exp 1001", status);
        end
    endtask

    task automatic test_sub_adc();
        @(negedge clk);
        op(1'b1, 4'b0100, 1'b1, 1'b1, 12'h005, 32'd5, 32'hA, 1'b1, 1'b0, 1'b0, 4'd1);
        sb.push_back({1'b1, 1'b0, 1'b0, 4'd1, 32'h0, 32'hA});
        @(posedge clk); #1;
        got = out_now(); e = sb.pop_front();
        checks++;
        if (got !== e) begin errors++; $display("FAIL sub_out got %h exp %h", got, e); end
        checks++;
        if (status !== 4'b0110) begin
            errors++; $display("FAIL sub_status got %b exp 0110", status);
        end
        @(negedge clk);
        op(1'b1, 4'b0011, 1'b0, 1'b1, 12'h001, 32'd1, 32'hB, 1'b1, 1'b0, 1'b0, 4'd2);
        sb.push_back({1'b1, 1'b0, 1'b0, 4'd2, 32'd3, 32'hB});
        @(posedge clk); #1;
        got = out_now(); e = sb.pop_front();
        checks++;
        if (got !== e) begin errors++; $display("FAIL adc_out got %h exp %h", got, e); end
        checks++;
        if (status !== 4'b0110) begin
            errors++; $display("FAIL adc_status_kept got %b exp 0110", status);
        end
    endtask

    typedef struct {
        logic [3:0]  cmd;
        logic        im;
        logic        mw;
        logic [11:0] so;
        logic [31:0] rn;
        logic [31:0] rm;
        logic [31:0] res;
    } vec_t;

    task automatic test_shifts();
        vec_t tbl[9];
        tbl[0] = '{4'b0001, 1'b1, 1'b0, 12'h2FF, 32'h0, 32'h0, 32'hF000000F};
        tbl[1] = '{4'b0001, 1'b0, 1'b0, 12'h240, 32'h0, 32'h80000000, 32'hF8000000};
        tbl[2] = '{4'b0001, 1'b0, 1'b0, 12'h400, 32'h0, 32'h000000AB, 32'h0000AB00};
        tbl[3] = '{4'b0001, 1'b0, 1'b0, 12'h220, 32'h0, 32'h000000F0, 32'h0000000F};
        tbl[4] = '{4'b0001, 1'b0, 1'b0, 12'h460, 32'h0, 32'h12345678, 32'h78123456};
        tbl[5] = '{4'b0001, 1'b0, 1'b0, 12'h040, 32'h0, 32'h80000001, 32'h80000001};
        tbl[6] = '{4'b1001, 1'b1, 1'b0, 12'h000, 32'h0, 32'h0, 32'hFFFFFFFF};
        tbl[7] = '{4'b0010, 1'b0, 1'b1, 12'hFFF, 32'h100, 32'hCAFE, 32'h000010FF};
        tbl[8] = '{4'b1000, 1'b1, 1'b0, 12'h00F, 32'hFF, 32'h55, 32'h000000F0};
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            op(1'b1, tbl[i].cmd, 1'b0, tbl[i].im, tbl[i].so, tbl[i].rn, tbl[i].rm,
               1'b0, 1'b0, tbl[i].mw, 4'(i));
            sb.push_back({1'b0, 1'b0, tbl[i].mw, 4'(i), tbl[i].res, tbl[i].rm});
            @(posedge clk); #1;
            got = out_now(); e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++; $display("FAIL val2_row%0d got %h exp %h", i, got, e);
            end
        end
        // Logic op with S keeps C and V from the earlier SUB.
        @(negedge clk);
        op(1'b1, 4'b0111, 1'b1, 1'b1, 12'h000, 32'h80000000, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0);
        @(posedge clk); #1;
        checks++;
        if (status !== 4'b1010) begin
            errors++; $display("FAIL orr_status got %b exp 1010", status);
        end
        @(negedge clk);
        op(1'b1, 4'b0000, 1'b1, 1'b1, 12'h001, 32'h1, 32'h0, 1'b1, 1'b0, 1'b0, 4'd6);
        @(posedge clk); #1;
        checks++;
        if ({alu_res, status} !== {32'h0, 4'b1010}) begin
            errors++; $display("FAIL badop got res %h st %b exp 0 1010", alu_res, status);
        end
    endtask

    task automatic test_branch();
        @(negedge clk);
        b = 1'b1; valid_in = 1'b1; pc_in = 32'h100; signed_imm_24 = 24'hFFFFFE;
        #1;
        checks++;
        if ({branch_taken, branch_addr} !== {1'b1, 32'h000000F8}) begin
            errors++;
            $display("FAIL branch_back got %b %h exp 1 000000f8", branch_taken, branch_addr);
        end
        pc_in = 32'h0; signed_imm_24 = 24'hFFFFFF;
        #1;
        checks++;
        if (branch_addr !== 32'hFFFFFFFC) begin
            errors++; $display("FAIL branch_wrap got %h exp fffffffc", branch_addr);
        end
        valid_in = 1'b0; pc_in = 32'h1000; signed_imm_24 = 24'h000010;
        #1;
        checks++;
        if ({branch_taken, branch_addr} !== {1'b0, 32'h00001040}) begin
            errors++;
            $display("FAIL branch_bubble got %b %h exp 0 00001040", branch_taken, branch_addr);
        end
        b = 1'b0;
    endtask

    task automatic test_freeze();
        @(negedge clk);
        op(1'b1, 4'b0010, 1'b1, 1'b1, 12'h000, 32'h0, 32'h55, 1'b0, 1'b0, 1'b0, 4'd5);
        sb.push_back({1'b0, 1'b0, 1'b0, 4'd5, 32'h0, 32'h55});
        @(posedge clk); #1;
        got = out_now(); e = sb.pop_front();
        checks++;
        if (got !== e || status !== 4'b0100) begin
            errors++; $display("FAIL pre_freeze got %h/%b exp %h/0100", got, status, e);
        end
        @(negedge clk);
        freeze = 1'b1;
        op(1'b1, 4'b0010, 1'b1, 1'b1, 12'h001, 32'h7FFFFFFF, 32'h99, 1'b1, 1'b0, 1'b0, 4'd9);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_now() !== e || status !== 4'b0100) begin
                errors++;
                $display("FAIL freeze_hold%0d got %h/%b exp %h/0100", i, out_now(), status, e);
            end
        end
        @(negedge clk);
        freeze = 1'b0;
        sb.push_back({1'b1, 1'b0, 1'b0, 4'd9, 32'h80000000, 32'h99});
        @(posedge clk); #1;
        got = out_now(); e = sb.pop_front();
        checks++;
        if (got !== e || status !== 4'b1001) begin
            errors++; $display("FAIL freeze_release got %h/%b exp %h/1001", got, status, e);
        end
        @(negedge clk);
        op(1'b0, 4'b0010, 1'b1, 1'b1, 12'h001, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 4'd1);
        @(posedge clk); #1;
        checks++;
        if ({wb_en_out, mem_r_en_out, mem_w_en_out, status} !== 7'b000_1001) begin
            errors++;
            $display("FAIL bubble got %b%b%b/%b exp 000/1001",
                     wb_en_out, mem_r_en_out, mem_w_en_out, status);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        op(1'b1, 4'b0010, 1'b1, 1'b1, 12'h001, 32'h1, 32'h77, 1'b1, 1'b0, 1'b0, 4'd2);
        sb.push_back({1'b1, 1'b0, 1'b0, 4'd2, 32'h2, 32'h77});
        @(posedge clk); #1;
        got = out_now(); e = sb.pop_front();
        checks++;
        if (got !== e) begin errors++; $display("FAIL pre_rst got %h exp %h", got, e); end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (out_now() !== 71'b0 || status !== 4'b0) begin
            errors++; $display("FAIL async_rst got %h/%b exp 0/0000", out_now(), status);
        end
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        op(1'b1, 4'b0010, 1'b0, 1'b0, 12'h008, 32'h40, 32'h3, 1'b1, 1'b1, 1'b0, 4'd7);
        #1;
        checks++;
        if (out_now() !== 71'b0) begin
            errors++; $display("FAIL rst_release_hold got %h exp 0", out_now());
        end
        sb.push_back({1'b1, 1'b1, 1'b0, 4'd7, 32'h48, 32'h3});
        @(posedge clk); #1;
        got = out_now(); e = sb.pop_front();
        checks++;
        if (got !== e) begin errors++; $display("FAIL ldr_after_rst got %h exp %h", got, e); end
    endtask

    initial begin
        test_reset();
        test_add_flags();
        test_sub_adc();
        test_shifts();
        test_branch();
        test_freeze();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
